aes_enc_round_seq: RTL and testbench

Iterative AES-128 encryption sequencer around a single `round_tf` instance (EN_MC=1). It holds the 128-bit cipher state and runs the initial AddRoundKey, then rounds 1–9 through `b_o` (with MixColumns) and round 10 through `b_sr_o` (without MixColumns). It uses one round transform per clock. Round keys come from an external key store that the block addresses through `rk_idx_o`. It sits between the core's block-input buffer and the ciphertext output path.

---
 rtl/aes_enc_round_seq.sv | 200 ++++++++++++++++++++
 tb/tb_aes_enc_round_seq.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_enc_round_seq.sv
// Iterative AES-128 encryptor: one round transform per clock around a single round_tf.
// Optional abort port is compiled in when AES_ENC_ROUND_SEQ_ABORT_EN is defined.

module round_tf #(
    parameter bit EN_MC = 1'b1
) (
    input  logic [127:0] a_i,
    output logic [127:0] b_sr_o,
    output logic [127:0] b_o
);
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // Inverse as x^254 (product of x^2..x^128), then the affine map; 0 maps to 0x63.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] sq;
        inv = 8'h01;
        sq  = x;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    // Byte 0 sits in the MSBs, so an ascending packed view indexes bytes directly.
    logic [0:15][7:0] st_b;
    logic [0:15][7:0] sb;
    logic [0:15][7:0] sr;
    logic [0:3][31:0] mc;

    assign st_b = a_i;

    always_comb begin
        sb = '0;
        sr = '0;
        mc = '0;
        for (int i = 0; i < 16; i++) sb[i] = sbox(st_b[i]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[4*c+r] = sb[4*((c+r)%4)+r];
        for (int c = 0; c < 4; c++)
            mc[c] = mix_col({sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3]});
    end

    assign b_sr_o = sr;

    generate
        if (EN_MC) begin : g_mc
            assign b_o = mc;
        end else begin : g_no_mc
            assign b_o = sr;
        end
    endgenerate
endmodule

module aes_enc_round_seq #(
    parameter int NR = 10
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         pt_valid_i,
    output logic         pt_ready_o,
    input  logic [127:0] pt_i,
    output logic [3:0]   rk_idx_o,
    input  logic [127:0] rk_i,
    output logic         ct_valid_o,
    input  logic         ct_ready_i,
    output logic [127:0] ct_o,
    output logic         busy_o
`ifdef AES_ENC_ROUND_SEQ_ABORT_EN
    ,
    input  logic         abort_i
`endif
);
    localparam logic [3:0] NR_L = 4'(NR);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} st_e;

    st_e          st_q;
    logic [127:0] state_q;
    logic [3:0]   rnd_q;
    logic         idle_q;
    logic         ct_valid_q;
    logic         busy_q;
    logic [127:0] b_sr;
    logic [127:0] b_mc;
    logic         abort;

`ifdef AES_ENC_ROUND_SEQ_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif

    round_tf #(.EN_MC(1'b1)) u_round (
        .a_i   (state_q),
        .b_sr_o(b_sr),
        .b_o   (b_mc)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q       <= IDLE;
            state_q    <= '0;
            rnd_q      <= '0;
            idle_q     <= 1'b1;
            ct_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (st_q)
                IDLE: begin
                    if (pt_valid_i && pt_ready_o) begin
                        state_q <= pt_i ^ rk_i;
                        rnd_q   <= 4'd1;
                        st_q    <= ROUND;
                        idle_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                ROUND: begin
                    if (abort) begin
                        state_q <= '0;
                        rnd_q   <= '0;
                        st_q    <= IDLE;
                        idle_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (rnd_q == 4'd0 || rnd_q > NR_L) begin
                        // Unreachable in normal operation; recover rather than spin.
                        rnd_q  <= '0;
                        st_q   <= IDLE;
                        idle_q <= 1'b1;
                        busy_q <= 1'b0;
                    end else if (rnd_q < NR_L) begin
                        state_q <= b_mc ^ rk_i;
                        rnd_q   <= rnd_q + 4'd1;
                    end else begin
                        state_q    <= b_sr ^ rk_i;
                        rnd_q      <= '0;
                        st_q       <= DONE;
                        ct_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (abort) begin
                        state_q    <= '0;
                        rnd_q      <= '0;
                        st_q       <= IDLE;
                        idle_q     <= 1'b1;
                        ct_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end else if (ct_ready_i) begin
                        st_q       <= IDLE;
                        idle_q     <= 1'b1;
                        ct_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end
                end
                default: begin
                    st_q       <= IDLE;
                    rnd_q      <= '0;
                    idle_q     <= 1'b1;
                    ct_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    // rnd_q is zero outside ROUND, so it doubles as the key index in every state.
    assign rk_idx_o   = rnd_q;
    assign pt_ready_o = idle_q & ~abort;
    assign ct_valid_o = ct_valid_q;
    assign ct_o       = state_q;
    assign busy_o     = busy_q;
endmodule

// File: tb/tb_aes_enc_round_seq.sv
// Bench for aes_enc_round_seq: directed steps with random data against a byte-level AES-128 model.
module tb_aes_enc_round_seq;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         pt_valid = 1'b0;
    logic         pt_ready;
    logic [127:0] pt = '0;
    logic [3:0]   rk_idx;
    logic [127:0] rk;
    logic         ct_valid;
    logic         ct_ready = 1'b0;
    logic [127:0] ct;
    logic         busy;
    logic         abort = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [7:0]   sbt [256];
    logic [127:0] rk_mem [16];

    int           cyc = 0;
    int           acc_t [$];
    logic [127:0] hs_ct [$];

    aes_enc_round_seq #(.NR(10)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .pt_valid_i(pt_valid),
        .pt_ready_o(pt_ready),
        .pt_i      (pt),
        .rk_idx_o  (rk_idx),
        .rk_i      (rk),
        .ct_valid_o(ct_valid),
        .ct_ready_i(ct_ready),
        .ct_o      (ct),
        .busy_o    (busy)
`ifdef AES_ENC_ROUND_SEQ_ABORT_EN
        ,
        .abort_i   (abort)
`endif
    );

    always #5 clk = ~clk;

    always_comb rk = rk_mem[rk_idx];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && pt_valid && pt_ready) acc_t.push_back(cyc);
        if (rst_n && ct_valid && ct_ready && !abort) hs_ct.push_back(ct);
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] b;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sbt[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                       ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    task automatic load_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]], sbt[t[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rk_mem[r] = (r < 11) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] p);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ rk_mem[0][127-8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbt[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[row+4*c] = t[row+4*((c+row)%4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk_mem[r][127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Flags packed as {pt_ready, ct_valid, busy, rk_idx}.
    function automatic logic [127:0] flags();
        return 128'({pt_ready, ct_valid, busy, rk_idx});
    endfunction

    function automatic logic [127:0] fl(input logic r, input logic v, input logic b,
                                        input logic [3:0] k);
        return 128'({r, v, b, k});
    endfunction

    // Starts and ends on a falling edge with the block idle.
    task automatic do_block(input logic [127:0] p, input logic [127:0] exp, input int hold,
                            input string tag);
        chk({tag, "_idle"}, flags(), fl(1'b1, 1'b0, 1'b0, 4'd0));
        pt_valid = 1'b1;
        pt = p;
        @(negedge clk);
        pt_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            chk({tag, "_round"}, flags(), fl(1'b0, 1'b0, 1'b1, 4'(k)));
            @(negedge clk);
        end
        chk({tag, "_done"}, flags(), fl(1'b0, 1'b1, 1'b1, 4'd0));
        chk({tag, "_ct"}, ct, exp);
        for (int h = 0; h < hold; h++) begin
            pt_valid = 1'($urandom_range(0, 1));
            pt = rnd128();
            @(negedge clk);
            chk({tag, "_hold_ct"}, ct, exp);
            chk({tag, "_hold_flags"}, flags(), fl(1'b0, 1'b1, 1'b1, 4'd0));
        end
        pt_valid = 1'b0;
        ct_ready = 1'b1;
        @(negedge clk);
        ct_ready = 1'b0;
        chk({tag, "_release"}, flags(), fl(1'b1, 1'b0, 1'b0, 4'd0));
    endtask

    initial begin
        logic [127:0] p1;
        int           a0;
        int           h0;
        int           sp;
        logic [127:0] c0;
        logic [127:0] c1;

        build_sbox();
        load_key(128'h0);

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_flags", flags(), fl(1'b1, 1'b0, 1'b0, 4'd0));
        chk("rst_ct", ct, 128'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_flags", flags(), fl(1'b1, 1'b0, 1'b0, 4'd0));

        // FIPS-197 C.1
        load_key(128'h000102030405060708090a0b0c0d0e0f);
        do_block(128'h00112233445566778899aabbccddeeff,
                 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, "fips_c1");

        // Backpressure with random data
        load_key(rnd128());
        p1 = rnd128();
        do_block(p1, aes_ref(p1), 20, "bp");

        for (int n = 0; n < 3; n++) begin
            load_key(rnd128());
            p1 = rnd128();
            do_block(p1, aes_ref(p1), int'($urandom_range(0, 3)), "rand");
        end

        // Back-to-back, all-zero key
        load_key(128'h0);
        p1 = rnd128();
        a0 = acc_t.size();
        h0 = hs_ct.size();
        ct_ready = 1'b1;
        pt_valid = 1'b1;
        pt = 128'h0;
        for (int n = 0; n < 40 && hs_ct.size() - h0 < 2; n++) begin
            @(negedge clk);
            if (acc_t.size() - a0 == 1) pt = p1;
            if (acc_t.size() - a0 >= 2) pt_valid = 1'b0;
        end
        pt_valid = 1'b0;
        ct_ready = 1'b0;
        chk("b2b_accepts", 128'(acc_t.size() - a0), 128'd2);
        chk("b2b_outputs", 128'(hs_ct.size() - h0), 128'd2);
        sp = (acc_t.size() >= a0 + 2) ? acc_t[a0+1] - acc_t[a0] : -1;
        chk("b2b_interval", 128'(sp), 128'd12);
        c0 = (hs_ct.size() >= h0 + 1) ? hs_ct[h0] : 128'hx;
        c1 = (hs_ct.size() >= h0 + 2) ? hs_ct[h0+1] : 128'hx;
        chk("b2b_ct_zero", c0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
        chk("b2b_ct_rand", c1, aes_ref(p1));
        @(negedge clk);

        // Asynchronous reset during round 5
        load_key(rnd128());
        pt_valid = 1'b1;
        pt = rnd128();
        @(negedge clk);
        pt_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_rst_round", flags(), fl(1'b0, 1'b0, 1'b1, 4'd5));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_flags", flags(), fl(1'b1, 1'b0, 1'b0, 4'd0));
        chk("mid_rst_ct", ct, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load_key(rnd128());
        p1 = rnd128();
        do_block(p1, aes_ref(p1), 1, "after_rst");

`ifdef AES_ENC_ROUND_SEQ_ABORT_EN
        h0 = hs_ct.size();
        // Abort while idle blocks acceptance
        abort = 1'b1;
        pt_valid = 1'b1;
        #1;
        chk("abort_idle_ready", 128'(pt_ready), 128'd0);
        @(negedge clk);
        abort = 1'b0;
        pt_valid = 1'b0;
        chk("abort_idle_busy", 128'(busy), 128'd0);
        // Abort in round 3
        pt_valid = 1'b1;
        pt = rnd128();
        @(negedge clk);
        pt_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_r3_round", flags(), fl(1'b0, 1'b0, 1'b1, 4'd3));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_r3_flags", flags(), fl(1'b1, 1'b0, 1'b0, 4'd0));
        chk("abort_r3_ct", ct, 128'h0);
        // Abort in DONE racing ct_ready
        pt_valid = 1'b1;
        pt = rnd128();
        @(negedge clk);
        pt_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort_done_state", flags(), fl(1'b0, 1'b1, 1'b1, 4'd0));
        abort = 1'b1;
        ct_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        ct_ready = 1'b0;
        chk("abort_done_flags", flags(), fl(1'b1, 1'b0, 1'b0, 4'd0));
        chk("abort_done_ct", ct, 128'h0);
        chk("abort_no_handshake", 128'(hs_ct.size() - h0), 128'd0);
        load_key(rnd128());
        p1 = rnd128();
        do_block(p1, aes_ref(p1), 0, "after_abort");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
